// File: rtl/tree_display_sequencer.sv
// Scans DIGITS positions through one shared tree-pattern decoder and steps a base
// code every STEP_FRAMES frames; digit i shows (base + i) mod 16 for a chase effect.
module tree_display_sequencer #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int STEP_FRAMES = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              pause,
  input  logic [3:0]        start_code,
  output logic [3:0]        code,
  output logic [DIGITS-1:0] dig_en,
  output logic              step_tick,
  output logic              frame_tick
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          state;
  logic [3:0]      base;
  logic            dir_dn;
  logic [SW-1:0]   scan_cnt;
  logic [FW-1:0]   step_cnt;
  logic [DW-1:0]   digit_idx;

  logic            scan_tc, frame_end, step_pt, dir_step;
  logic [DW-1:0]   idx_nxt;
  logic [3:0]      base_step, base_nxt;

  always_comb begin
    scan_tc   = (scan_cnt == SW'(SCAN_DIV - 1));
    frame_end = scan_tc && (digit_idx == DW'(DIGITS - 1));
    step_pt   = frame_end && !pause && (step_cnt == FW'(STEP_FRAMES - 1));
    idx_nxt   = frame_end ? '0 : digit_idx + DW'(1);
    base_step = base;
    dir_step  = dir_dn;
    case (mode)
      2'b00: base_step = base;
      2'b01: base_step = base + 4'd1;
      2'b10: base_step = base - 4'd1;
      default: begin
        // bounce reflects at the ends so each extreme is shown once per pass
        if (!dir_dn) begin
          if (base == 4'd15) begin
            dir_step  = 1'b1;
            base_step = 4'd14;
          end else begin
            base_step = base + 4'd1;
          end
        end else begin
          if (base == 4'd0) begin
            dir_step  = 1'b0;
            base_step = 4'd1;
          end else begin
            base_step = base - 4'd1;
          end
        end
      end
    endcase
    base_nxt = step_pt ? base_step : base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      dir_dn     <= 1'b0;
      scan_cnt   <= '0;
      step_cnt   <= '0;
      digit_idx  <= '0;
      code       <= '0;
      dig_en     <= '0;
      step_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      step_tick  <= 1'b0;
      frame_tick <= 1'b0;
      case (state)
        IDLE: begin
          code   <= '0;
          dig_en <= '0;
          if (en) state <= LOAD;
        end
        LOAD: begin
          base      <= start_code;
          dir_dn    <= 1'b0;
          scan_cnt  <= '0;
          step_cnt  <= '0;
          digit_idx <= '0;
          if (en) begin
            state  <= RUN;
            dig_en <= DIGITS'(1);
            code   <= start_code;
          end else begin
            state  <= IDLE;
            dig_en <= '0;
            code   <= '0;
          end
        end
        RUN: begin
          if (!en) begin
            state  <= IDLE;
            dig_en <= '0;
            code   <= '0;
          end else if (scan_tc) begin
            scan_cnt  <= '0;
            digit_idx <= idx_nxt;
            dig_en    <= DIGITS'(1) << idx_nxt;
            // digit 0 of the next frame already shows the stepped base
            code      <= base_nxt + 4'(idx_nxt);
            if (frame_end) begin
              frame_tick <= 1'b1;
              if (!pause) begin
                if (step_pt) begin
                  step_cnt  <= '0;
                  step_tick <= 1'b1;
                  base      <= base_step;
                  dir_dn    <= dir_step;
                end else begin
                  step_cnt <= step_cnt + FW'(1);
                end
              end
            end
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_display_sequencer.sv
// Scoreboard bench: each run segment pushes expected display/frame/step events
// with their cycle stamps; a negedge monitor pops and compares as the DUT emits.
module tb_tree_display_sequencer;
  localparam int DIGITS = 4, SCAN_DIV = 4, STEP_FRAMES = 2;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, pause = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] start_code = 4'd0;
  logic [3:0] code;
  logic [DIGITS-1:0] dig_en;
  logic step_tick, frame_tick;

  int cyc = 0, checks = 0, errors = 0;
  bit mon_on = 1'b0;

  typedef struct {int cyc; logic [3:0] de; logic [3:0] cd;} ev_t;
  ev_t disp_q[$];
  int  frame_q[$], step_q[$];
  logic [3:0] fb [16];
  bit         st [16];
  logic [3:0] seq [8];

  tree_display_sequencer #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .STEP_FRAMES(STEP_FRAMES)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .pause(pause), .start_code(start_code),
    .code(code), .dig_en(dig_en), .step_tick(step_tick), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cyc %0d", name, got, exp, cyc);
    end
  endtask

  int   mon_c;
  ev_t  mon_ev;
  logic [7:0] prev = 8'h00;

  always @(negedge clk) begin
    if (mon_on) begin
      if (step_tick !== 1'b0) begin
        if (step_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL step_unexpected got step_tick=%b expected none at cyc %0d", step_tick, cyc);
        end else begin
          mon_c = step_q.pop_front();
          chk("step_cyc", cyc, mon_c);
        end
      end
      if (frame_tick !== 1'b0) begin
        if (frame_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected got frame_tick=%b expected none at cyc %0d", frame_tick, cyc);
        end else begin
          mon_c = frame_q.pop_front();
          chk("frame_cyc", cyc, mon_c);
        end
      end
      if ({dig_en, code} !== prev) begin
        if (disp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL disp_unexpected got dig_en=%b code=%0d expected none at cyc %0d", dig_en, code, cyc);
        end else begin
          mon_ev = disp_q.pop_front();
          chk("disp_cyc", cyc, mon_ev.cyc);
          chk("disp_dig_en", dig_en, mon_ev.de);
          chk("disp_code", code, mon_ev.cd);
        end
        prev = {dig_en, code};
      end
    end
  end

  // plain stepping plan: base seq[n] during frames 2n and 2n+1, step after odd frames
  task automatic plan();
    for (int f = 0; f < 16; f++) begin
      fb[f] = seq[f / 2];
      st[f] = (f % 2 == 1);
    end
  endtask

  // en rises; digits show for ncyc cycles after digit 0 appears, then en drops (or rst hits)
  task automatic run_seg(input logic [3:0] sc, input logic [1:0] md, input bit pz, input int ncyc,
                         input bit use_rst, input int mchg, input logic [1:0] md2, input int prel);
    int k, r, s, d, f;
    ev_t ev;
    @(negedge clk);
    start_code = sc; mode = md; pause = pz; en = 1'b1;
    k = cyc + 1;
    for (int t = k + 1; t <= k + ncyc; t++) begin
      r = t - k - 1;
      if (r % SCAN_DIV == 0) begin
        s = r / SCAN_DIV; d = s % DIGITS; f = s / DIGITS;
        ev.cyc = t; ev.de = 4'(1 << d); ev.cd = 4'(fb[f] + d);
        disp_q.push_back(ev);
        if (d == 0 && f > 0) begin
          frame_q.push_back(t);
          if (st[f-1]) step_q.push_back(t);
        end
      end
    end
    ev.cyc = k + ncyc + 1; ev.de = 4'd0; ev.cd = 4'd0;
    disp_q.push_back(ev);
    while (cyc < k + ncyc) begin
      @(negedge clk);
      if (cyc == k + 1) start_code = ~sc;
      if (cyc == k + mchg) mode = md2;
      if (cyc == k + prel) pause = 1'b0;
    end
    if (use_rst) rst = 1'b1; else en = 1'b0;
    @(negedge clk);
    chk("drop_dig_en", dig_en, 0);
    chk("drop_code", code, 0);
    if (use_rst) begin
      chk("rst_step_tick", step_tick, 0);
      chk("rst_frame_tick", frame_tick, 0);
      rst = 1'b0; en = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_code", code, 0);
    chk("reset_dig_en", dig_en, 0);
    chk("reset_step_tick", step_tick, 0);
    chk("reset_frame_tick", frame_tick, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    // up from 5: frames 5,5 then 6,6 then 7
    seq = '{4'd5, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    plan(); run_seg(4'd5, 2'b01, 1'b0, 65, 1'b0, -1, 2'b00, -1);
    // up wrap 14 -> 15
    seq = '{4'd14, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    plan(); run_seg(4'd14, 2'b01, 1'b0, 33, 1'b0, -1, 2'b00, -1);
    // down wrap 0 -> 15
    seq = '{4'd0, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    plan(); run_seg(4'd0, 2'b10, 1'b0, 33, 1'b0, -1, 2'b00, -1);
    // bounce 14,15,14,13 then switch to up mid frame 6: 14,15,0
    seq = '{4'd14, 4'd15, 4'd14, 4'd13, 4'd14, 4'd15, 4'd0, 4'd0};
    plan(); run_seg(4'd14, 2'b11, 1'b0, 193, 1'b0, 104, 2'b01, -1);
    // pause for frames 0..2, released mid frame 3; step lands after frame 4
    for (int f = 0; f < 16; f++) begin
      fb[f] = (f <= 4) ? 4'd3 : 4'd4;
      st[f] = (f == 4);
    end
    run_seg(4'd3, 2'b01, 1'b1, 81, 1'b0, -1, 2'b00, 56);
    // en drop mid-scan, then restart with a new start code
    seq = '{4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    plan(); run_seg(4'd9, 2'b01, 1'b0, 7, 1'b0, -1, 2'b00, -1);
    seq = '{4'd12, 4'd13, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    plan(); run_seg(4'd12, 2'b01, 1'b0, 17, 1'b0, -1, 2'b00, -1);
    // reset mid-RUN with en still high
    seq = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    plan(); run_seg(4'd2, 2'b01, 1'b0, 10, 1'b1, -1, 2'b00, -1);

    repeat (6) @(negedge clk);
    chk("disp_q_empty", disp_q.size(), 0);
    chk("frame_q_empty", frame_q.size(), 0);
    chk("step_q_empty", step_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout reached at cyc %0d expected completion earlier", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/tree_display_sequencer.md
Name: tree_display_sequencer

Overview:
Drives the 4-bit code input of the Christmas-tree 7-segment pattern decoder. It also time-multiplexes one shared decoder across DIGITS display positions. The block scans the digits at a fixed rate and steps a base pattern code every STEP_FRAMES scan frames, using a selectable mode (hold, up, down, bounce). Each digit shows (base + digit index) mod 16, which gives a chase effect across the tree. It sits between the top-level switch inputs and the decoder; the decoder segment outputs go to the shared segment bus.

Parameters:
DIGITS, 4, number of multiplexed digit positions (1..8)
SCAN_DIV, 50000, clock cycles each digit stays enabled (>=2)
STEP_FRAMES, 100, full scan frames between base-code steps (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  run enable; low blanks the display and returns to IDLE
mode  in  2  00 hold, 01 up, 10 down, 11 bounce
pause  in  1  freezes stepping; scanning continues
start_code  in  4  base code loaded when leaving IDLE
code  out  4  code to the pattern decoder X input
dig_en  out  DIGITS  one-hot digit enable, active-high, aligned with code
step_tick  out  1  one-cycle pulse when the base step point is reached
frame_tick  out  1  one-cycle pulse at the end of each scan frame

Behaviour:
- Reset (clk edge with rst=1), highest priority over all other inputs:
  - state=IDLE, base=0, dir=up, scan_cnt=0, step_cnt=0, digit_idx=0.
  - Outputs: code=0, dig_en=0, step_tick=0, frame_tick=0.
  - Reset asserted mid-RUN gives the same result on the next edge.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: dig_en=0, code=0. Goes to LOAD on an edge with en=1.
  - LOAD: lasts exactly one cycle.
    - base<=start_code; scan_cnt, step_cnt, digit_idx cleared; dir=up.
    - Goes to RUN. On the same edge dig_en<=one-hot(0) and code<=start_code.
  - RUN: any edge with en=0 goes to IDLE, and dig_en<=0, code<=0 on that edge. en=0 in LOAD also goes to IDLE.
- Latency: en sampled high at edge k. State is LOAD after edge k. Digit 0 is displayed after edge k+1.
- Scan, in RUN:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal count: scan_cnt<=0 and digit_idx<=(digit_idx+1) mod DIGITS. dig_en and code update on that same edge.
  - Each digit is therefore enabled for exactly SCAN_DIV cycles.
  - code = (base + digit_idx) mod 16, 4-bit wrap.
- Frame end: scan terminal count with digit_idx=DIGITS-1.
  - frame_tick pulses for the cycle after that edge.
  - Frame length is DIGITS*SCAN_DIV cycles.
- Step, evaluated at frame end with pause=0:
  - If step_cnt=STEP_FRAMES-1: step_cnt<=0, step_tick pulses, base updated per the mode sampled on that edge.
  - Otherwise step_cnt increments.
- pause=1 at frame end: step_cnt and base hold; no step_tick. frame_tick still pulses.
- Base update on the step edge:
  - The new base is visible in the code for digit 0 of the next frame, on the same edge.
  - hold: base unchanged; step_tick still pulses.
  - up: base+1, 15 wraps to 0.
  - down: base-1, 0 wraps to 15.
  - bounce, dir=up: at base=15, dir<=down and base<=14; otherwise base+1.
  - bounce, dir=down: at base=0, dir<=up and base<=1; otherwise base-1.
  - dir persists across mode changes. It is reset only by rst or LOAD.
- Mode, pause and start_code changes mid-step have no effect until the next evaluation point. start_code is sampled only in LOAD.
- DIGITS=1: digit_idx stays 0, and every scan terminal count is a frame end.

Test Plan:
All cases use DIGITS=4, SCAN_DIV=4, STEP_FRAMES=2.
- Reset then en=1, start_code=5, mode=01:
  - RUN after 2 edges.
  - dig_en steps 0001,0010,0100,1000, each for 4 cycles.
  - code steps 5,6,7,8.
  - frame_tick after 16 cycles; step_tick after 32 cycles.
  - Next frame codes are 6,7,8,9.
- Wrap, mode=01, start_code=14:
  - Codes in frame 1: 14,15,0,1.
  - After the step: 15,0,1,2.
  - mode=10, start_code=0: the step gives base=15.
- Bounce, start_code=14, mode=11:
  - Successive bases 14,15,14,13.
  - Switch to mode 01 while dir=down: bases continue 14,15,0.
- pause=1 held for 3 frames:
  - frame_tick pulses 3 times, step_tick never pulses, base is unchanged.
  - Release pause: the step occurs after the remaining frame count.
- Control events mid-scan:
  - en=0 mid-RUN: dig_en=0 and code=0 on the next edge.
  - en=1 again: LOAD restarts with the new start_code and digit 0.
  - rst=1 mid-RUN: all outputs are 0 on the next edge, even with en=1.
